miner_slave_regs: RTL and testbench
===================================

MINER_SLAVE_REGS -- requirements
Module: miner_slave_regs

Interface
REQ-001 SHALL: clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL: n_rst  input  1  asynchronous active-low reset.
REQ-003 SHALL: slaveAddr  input  5  word address, 0-31.
REQ-004 SHALL: slaveWriteData  input  32  write data.
REQ-005 SHALL: slaveWrite / slaveRead / slaveChipSelect  input  1 each  access qualifiers; an access is valid only with slaveChipSelect=1.
REQ-006 SHALL: slaveReadData  output  32  registered read data.
REQ-007 SHALL: target  output  256  assembled difficulty target to hash core.
REQ-008 SHALL: header  output  608  assembled 76-byte block header (nonce excluded) to hash core.
REQ-009 SHALL: start / abort  output  1 each  single-cycle pulses to hash core.
REQ-010 SHALL: coreFound  input  1  core found a valid nonce (level, sampled each cycle); coreNonce  input  32  nonce valid when coreFound=1.

Function
REQ-011 SHALL: address map: 0 status (RO), 1 control (WO), 2-9 target words (2 = target[31:0] ... 9 = target[255:224]), 10 nonce (RO), 11-29 header words (29 = header[607:576] ... 11 = header[31:0]), 30-31 reserved.
REQ-012 SHALL: FSM states, encoding = status value: IDLE=0, TARGET_OK=1, RUNNING=2, FOUND=3; status reads return {30'b0, state}.
REQ-013 SHALL: control write 1 in IDLE, TARGET_OK or FOUND -> TARGET_OK.
REQ-014 SHALL: control write 2 in TARGET_OK -> RUNNING, start=1 for exactly the following cycle.
REQ-015 SHALL: control write 4 in RUNNING -> IDLE, abort=1 for exactly the following cycle.
REQ-016 SHALL: control writes of any other value, or in any other state, are ignored.
REQ-017 SHALL: coreFound=1 in RUNNING -> FOUND, coreNonce latched into nonce register the same edge; coreFound ignored in other states.
REQ-018 SHALL: coreFound and abort write in the same cycle -> found wins, FOUND, no abort pulse.
REQ-019 SHALL: writes to target/header words update that word on the next edge, except in RUNNING where they are ignored (registers locked).
REQ-020 SHALL: read latency 1 cycle: slaveReadData reflects register contents at the read edge; simultaneous read and write to the same address returns the pre-write value.
REQ-021 SHALL: reads of addresses 1 and 30-31 return 0; writes to 0, 10, 30, 31 are ignored.
REQ-022 SHALL: slaveReadData holds its last value when no valid read is presented.
REQ-023 SHALL: nonce register retains its value until the next FOUND transition.

Reset
REQ-024 SHALL: on n_rst=0: state IDLE, target/header/nonce all 0, slaveReadData=0, start=0, abort=0, taking effect immediately without clk.
REQ-025 SHALL: reset asserted in RUNNING produces no abort pulse; the core is reset by the same n_rst.

Configuration
REQ-026 SHALL: macro MINER_REG_READBACK_EN defined -> reads of addresses 2-9 and 11-29 return stored target/header words; undefined -> those reads return 0 and readback mux logic is omitted.

Structure
REQ-027 SHALL: shared package miner_pkg holds address constants (ADDR_STATUS, ADDR_CONTROL, ADDR_TARGET_LO/HI, ADDR_NONCE, ADDR_HDR_LO/HI), control codes (CTRL_LOAD_TARGET=1, CTRL_START=2, CTRL_ABORT=4), and the state enum.
REQ-028 SHALL: flat single module, no sub-modules; register storage as word arrays indexed by address offset.

Verification
REQ-029 SHALL: reset, read addr 0 -> 0x00000000; start and abort both 0.
REQ-030 SHALL: write target words 9..2 with 0x01000000,0,...,0, control=1 -> status 1, target = 256'h01 followed by 62 zero hex digits.
REQ-031 SHALL: write header words 29..11 with 0x61000000 then zeros, control=2 -> start high exactly one cycle, status 2, header[607:576]=0x61000000.
REQ-032 SHALL: in RUNNING drive coreFound=1, coreNonce=0x0000BEEF -> status 3, read addr 10 -> 0x0000BEEF; write to addr 5 while RUNNING leaves target unchanged.
REQ-033 SHALL: in RUNNING write control=4 simultaneous with coreFound=1 -> status 3, abort never asserted; repeat without coreFound -> status 0, abort one-cycle pulse.
REQ-034 SHALL: read addr 20 after writing 0x12345678 -> 0x12345678 with MINER_REG_READBACK_EN, 0x00000000 without.

Source files
------------

// File: rtl/miner_slave_regs_pkg.sv
// rtl/miner_slave_regs_pkg.sv - shared address map, control codes and FSM state enum for the miner register slave

package miner_pkg;

  localparam logic [4:0] ADDR_STATUS    = 5'd0;
  localparam logic [4:0] ADDR_CONTROL   = 5'd1;
  localparam logic [4:0] ADDR_TARGET_LO = 5'd2;
  localparam logic [4:0] ADDR_TARGET_HI = 5'd9;
  localparam logic [4:0] ADDR_NONCE     = 5'd10;
  localparam logic [4:0] ADDR_HDR_LO    = 5'd11;
  localparam logic [4:0] ADDR_HDR_HI    = 5'd29;

  localparam int NUM_TARGET_WORDS = 8;
  localparam int NUM_HDR_WORDS    = 19;

  localparam logic [31:0] CTRL_LOAD_TARGET = 32'd1;
  localparam logic [31:0] CTRL_START       = 32'd2;
  localparam logic [31:0] CTRL_ABORT       = 32'd4;

  // Encoding is visible to software as the status register value.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TARGET_OK = 2'd1,
    RUNNING   = 2'd2,
    FOUND     = 2'd3
  } state_t;

endpackage

// File: rtl/miner_slave_regs_if.sv
// rtl/miner_slave_regs_if.sv - word-addressed register slave bus between host and miner_slave_regs

interface miner_slave_regs_if;
  logic [4:0]  slaveAddr;
  logic [31:0] slaveWriteData;
  logic        slaveWrite;
  logic        slaveRead;
  logic        slaveChipSelect;
  logic [31:0] slaveReadData;

  modport master (
    output slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
    input  slaveReadData
  );

  modport slave (
    input  slaveAddr, slaveWriteData, slaveWrite, slaveRead, slaveChipSelect,
    output slaveReadData
  );
endinterface

// File: rtl/miner_slave_regs.sv
// rtl/miner_slave_regs.sv - miner control/status registers, target/header staging and hash-core handshake
// Optional target/header readback: define MINER_REG_READBACK_EN.

module miner_slave_regs
  import miner_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  miner_slave_regs_if.slave bus,
  output logic [255:0]      target,
  output logic [607:0]      header,
  output logic              start,
  output logic              abort,
  input  logic              coreFound,
  input  logic [31:0]       coreNonce
);

  state_t      state;
  state_t      state_nxt;
  logic        start_nxt;
  logic        abort_nxt;
  logic        nonce_ld;
  logic [31:0] nonce;
  logic [31:0] target_words [NUM_TARGET_WORDS];
  logic [31:0] header_words [NUM_HDR_WORDS];
  logic [31:0] rd_mux;

  logic       wr_en;
  logic       rd_en;
  logic       ctrl_wr;
  logic       is_target;
  logic       is_hdr;
  logic [2:0] tgt_idx;
  logic [4:0] hdr_idx;

  assign wr_en     = bus.slaveChipSelect & bus.slaveWrite;
  assign rd_en     = bus.slaveChipSelect & bus.slaveRead;
  assign ctrl_wr   = wr_en && (bus.slaveAddr == ADDR_CONTROL);
  assign is_target = (bus.slaveAddr >= ADDR_TARGET_LO) && (bus.slaveAddr <= ADDR_TARGET_HI);
  assign is_hdr    = (bus.slaveAddr >= ADDR_HDR_LO) && (bus.slaveAddr <= ADDR_HDR_HI);
  assign tgt_idx   = 3'(bus.slaveAddr - ADDR_TARGET_LO);
  assign hdr_idx   = bus.slaveAddr - ADDR_HDR_LO;

  for (genvar i = 0; i < NUM_TARGET_WORDS; i++) begin : g_target
    assign target[32*i +: 32] = target_words[i];
  end

  for (genvar i = 0; i < NUM_HDR_WORDS; i++) begin : g_header
    assign header[32*i +: 32] = header_words[i];
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    nonce_ld  = 1'b0;
    case (state)
      IDLE, FOUND: begin
        if (ctrl_wr && bus.slaveWriteData == CTRL_LOAD_TARGET) state_nxt = TARGET_OK;
      end
      TARGET_OK: begin
        if (ctrl_wr && bus.slaveWriteData == CTRL_START) begin
          state_nxt = RUNNING;
          start_nxt = 1'b1;
        end
      end
      RUNNING: begin
        // A result from the core outranks a concurrent abort request.
        if (coreFound) begin
          state_nxt = FOUND;
          nonce_ld  = 1'b1;
        end else if (ctrl_wr && bus.slaveWriteData == CTRL_ABORT) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      start <= 1'b0;
      abort <= 1'b0;
      nonce <= '0;
    end else begin
      state <= state_nxt;
      start <= start_nxt;
      abort <= abort_nxt;
      if (nonce_ld) nonce <= coreNonce;
    end
  end

  // Target and header are locked while the core is hashing them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_TARGET_WORDS; i++) target_words[i] <= '0;
      for (int i = 0; i < NUM_HDR_WORDS; i++) header_words[i] <= '0;
    end else if (wr_en && state != RUNNING) begin
      if (is_target) target_words[tgt_idx] <= bus.slaveWriteData;
      if (is_hdr) header_words[hdr_idx] <= bus.slaveWriteData;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.slaveAddr == ADDR_STATUS) begin
      rd_mux = {30'b0, state};
    end else if (bus.slaveAddr == ADDR_NONCE) begin
      rd_mux = nonce;
`ifdef MINER_REG_READBACK_EN
    end else if (is_target) begin
      rd_mux = target_words[tgt_idx];
    end else if (is_hdr) begin
      rd_mux = header_words[hdr_idx];
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.slaveReadData <= '0;
    end else if (rd_en) begin
      bus.slaveReadData <= rd_mux;
    end
  end

endmodule

// File: tb/tb_miner_slave_regs.sv
// tb/tb_miner_slave_regs.sv - scoreboard bench for miner_slave_regs with a behavioural register model

module tb_miner_slave_regs;

  logic         clk;
  logic         n_rst;
  logic [255:0] target;
  logic [607:0] header;
  logic         start;
  logic         abort;
  logic         coreFound;
  logic [31:0]  coreNonce;

  miner_slave_regs_if bus_if ();

  miner_slave_regs dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus_if),
    .target    (target),
    .header    (header),
    .start     (start),
    .abort     (abort),
    .coreFound (coreFound),
    .coreNonce (coreNonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int tag; logic [31:0] val; } rd_exp_t;
  typedef struct { int tag; logic s; logic a; } pulse_exp_t;

  rd_exp_t    rq[$];
  pulse_exp_t pq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [31:0] last_rd = '0;

  // Reference model: software-visible registers and state number.
  int          m_st;
  logic [31:0] m_tgt [8];
  logic [31:0] m_hdr [19];
  logic [31:0] m_nonce;

  task automatic chk(input string name, input logic [607:0] act, input logic [607:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = 0;
    m_nonce = '0;
    for (int i = 0; i < 8; i++) m_tgt[i] = '0;
    for (int i = 0; i < 19; i++) m_hdr[i] = '0;
  endfunction

  function automatic logic [255:0] model_target();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = m_tgt[i];
    return t;
  endfunction

  function automatic logic [607:0] model_header();
    logic [607:0] h;
    for (int i = 0; i < 19; i++) h[32*i +: 32] = m_hdr[i];
    return h;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return 32'(m_st);
    if (a == 10) return m_nonce;
`ifdef MINER_REG_READBACK_EN
    if (a >= 2 && a <= 9) return m_tgt[a-2];
    if (a >= 11 && a <= 29) return m_hdr[a-11];
`endif
    return 32'h0;
  endfunction

  // One bus cycle: inputs applied at a falling edge take effect at the next rising edge.
  task automatic step(input logic cs, input logic wr, input logic rd, input logic [4:0] a,
                      input logic [31:0] d, input logic f, input logic [31:0] n);
    bit ctrl, s_e, f_e, a_e;
    int ai;
    @(negedge clk);
    chk("target_bus", {352'b0, target}, {352'b0, model_target()});
    chk("header_bus", header, model_header());
    bus_if.slaveChipSelect = cs;
    bus_if.slaveWrite      = wr;
    bus_if.slaveRead       = rd;
    bus_if.slaveAddr       = a;
    bus_if.slaveWriteData  = d;
    coreFound              = f;
    coreNonce              = n;
    ai   = int'(a);
    ctrl = cs && wr && ai == 1;
    if (cs && rd) rq.push_back('{cyc + 1, model_read(ai)});
    s_e = (m_st == 1) && ctrl && d == 32'd2;
    f_e = (m_st == 2) && f;
    a_e = (m_st == 2) && !f && ctrl && d == 32'd4;
    pq.push_back('{cyc + 1, s_e, a_e});
    if (cs && wr && m_st != 2) begin
      if (ai >= 2 && ai <= 9) m_tgt[ai-2] = d;
      if (ai >= 11 && ai <= 29) m_hdr[ai-11] = d;
    end
    if (f_e) begin
      m_nonce = n;
      m_st = 3;
    end else if (a_e) m_st = 0;
    else if (s_e) m_st = 2;
    else if (ctrl && d == 32'd1 && m_st != 2) m_st = 1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b0, 1'b1, a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!n_rst) last_rd = '0;
    while (pq.size() > 0 && pq[0].tag == cyc) begin
      pulse_exp_t p;
      p = pq.pop_front();
      chk("start_pulse", {607'b0, start}, {607'b0, p.s});
      chk("abort_pulse", {607'b0, abort}, {607'b0, p.a});
    end
    if (rq.size() > 0 && rq[0].tag == cyc) begin
      rd_exp_t r;
      r = rq.pop_front();
      chk("read_data", {576'b0, bus_if.slaveReadData}, {576'b0, r.val});
      last_rd = r.val;
    end else begin
      chk("read_hold", {576'b0, bus_if.slaveReadData}, {576'b0, last_rd});
    end
  end

  initial begin
    logic [255:0] tgt_req;
    logic [4:0]   ra;
    logic [31:0]  rdv;
    int           op;

    n_rst = 1'b0;
    bus_if.slaveChipSelect = 1'b0;
    bus_if.slaveWrite      = 1'b0;
    bus_if.slaveRead       = 1'b0;
    bus_if.slaveAddr       = '0;
    bus_if.slaveWriteData  = '0;
    coreFound              = 1'b0;
    coreNonce              = '0;
    model_reset();
    #3;
    chk("reset_rdata", {576'b0, bus_if.slaveReadData}, 608'h0);
    chk("reset_start", {607'b0, start}, 608'h0);
    chk("reset_abort", {607'b0, abort}, 608'h0);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b1;

    rd(5'd0);
    idle();

    // Load a target and arm it.
    wr(5'd9, 32'h0100_0000);
    for (int i = 8; i >= 2; i--) wr(5'(i), 32'h0);
    wr(5'd1, 32'd1);
    idle();
    tgt_req = 256'h01 << 248;
    chk("target_loaded", {352'b0, target}, {352'b0, tgt_req});
    rd(5'd0);
    idle();
    chk("status_target_ok", {576'b0, bus_if.slaveReadData}, 608'h1);

    wr(5'd29, 32'h6100_0000);
    for (int i = 28; i >= 11; i--) wr(5'(i), 32'h0);
    wr(5'd1, 32'd2);
    idle();
    chk("start_high", {607'b0, start}, 608'h1);
    idle();
    chk("start_low", {607'b0, start}, 608'h0);
    chk("header_top", {576'b0, header[607:576]}, 608'h6100_0000);
    rd(5'd0);
    idle();
    chk("status_running", {576'b0, bus_if.slaveReadData}, 608'h2);

    // Locked target, then core reports a nonce.
    wr(5'd5, 32'hDEAD_BEEF);
    idle();
    chk("target_locked", {352'b0, target}, {352'b0, tgt_req});
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_BEEF);
    rd(5'd0);
    idle();
    chk("status_found", {576'b0, bus_if.slaveReadData}, 608'h3);
    rd(5'd10);
    idle();
    chk("nonce_read", {576'b0, bus_if.slaveReadData}, 608'hBEEF);

    // Abort racing a found result, then a clean abort.
    wr(5'd1, 32'd1);
    wr(5'd1, 32'd2);
    step(1'b1, 1'b1, 1'b0, 5'd1, 32'd4, 1'b1, 32'h1234_0001);
    idle();
    chk("abort_lost_race", {607'b0, abort}, 608'h0);
    rd(5'd0);
    idle();
    chk("status_found_race", {576'b0, bus_if.slaveReadData}, 608'h3);
    wr(5'd1, 32'd1);
    wr(5'd1, 32'd2);
    wr(5'd1, 32'd4);
    idle();
    chk("abort_high", {607'b0, abort}, 608'h1);
    idle();
    chk("abort_low", {607'b0, abort}, 608'h0);
    rd(5'd0);
    idle();
    chk("status_idle", {576'b0, bus_if.slaveReadData}, 608'h0);

    wr(5'd20, 32'h1234_5678);
    rd(5'd20);
    idle();
`ifdef MINER_REG_READBACK_EN
    chk("hdr20_readback", {576'b0, bus_if.slaveReadData}, 608'h1234_5678);
`else
    chk("hdr20_readback", {576'b0, bus_if.slaveReadData}, 608'h0);
`endif
    rd(5'd1);
    rd(5'd31);
    idle();

    // Reset while running: no abort, everything cleared asynchronously.
    wr(5'd1, 32'd1);
    wr(5'd1, 32'd2);
    idle();
    idle();
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_rdata", {576'b0, bus_if.slaveReadData}, 608'h0);
    chk("midreset_target", {352'b0, target}, 608'h0);
    chk("midreset_header", header, 608'h0);
    chk("midreset_abort", {607'b0, abort}, 608'h0);
    @(negedge clk);
    chk("midreset_abort_after_edge", {607'b0, abort}, 608'h0);
    #2 n_rst = 1'b1;
    model_reset();

    for (int k = 0; k < 1500; k++) begin
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: ra = 5'd1;
        1: ra = 5'd0;
        2: ra = 5'd10;
        default: ra = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 4))
        0: rdv = 32'd1;
        1: rdv = 32'd2;
        2: rdv = 32'd4;
        default: rdv = $urandom;
      endcase
      step(($urandom_range(0, 7) != 0), (op < 5), (op >= 3), ra, rdv,
           ($urandom_range(0, 7) == 0), $urandom);
    end
    idle();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", 608'(rq.size() + pq.size()), 608'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
